mt_gen_par: RTL and testbench
=============================

MT_GEN_PAR -- requirements
Module: mt_gen_par

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width; legal values are 32 (MT19937) and 64 (MT19937-64), and any other value is an elaboration error.
REQ-002 SHALL have parameter AW, default 10, meaning state-RAM address width; AW SHALL be at least ceil(log2(N)).
REQ-003 SHALL have ports clk (input, 1, clock) and reset (input, 1, asynchronous active-high reset).
REQ-004 SHALL have port init (input, 1): start generation from RAM contents already loaded.
REQ-005 SHALL have ports seed_load (input, 1) and seed (input, W): seed the generator internally from seed.
REQ-006 SHALL have port busy (output, 1): high while in SEED or PRIME.
REQ-007 SHALL have ports dout (output, W), dout_valid (output, 1) and dout_ready (input, 1): tempered output stream.
REQ-008 SHALL have ports raddr0 and raddr1 (output, AW), ren (output, 1), rdata0 and rdata1 (input, W): two read ports with 1-cycle latency; rdata SHALL hold its value while ren=0.
REQ-009 SHALL have ports waddr (output, AW), wen (output, 1) and wdata (output, W): single write port.

Function
REQ-010 SHALL use these constants for W=32: N=624, M=397, A=0x9908B0DF, upper mask 0x80000000, u=11, s=7, B=0x9D2C5680, t=15, C=0xEFC60000, l=18, f=1812433253.
REQ-011 SHALL use these constants for W=64: N=312, M=156, A=0xB5026F5AA96619E9, upper mask 0xFFFFFFFF80000000, u=29 with mask D=0x5555555555555555, s=17, B=0x71D67FFFEDA60000, t=37, C=0xFFF7EEE000000000, l=43, f=6364136223846793005.
REQ-012 SHALL implement states IDLE, SEED, PRIME and RUN.
REQ-013 SHALL apply this transition priority on each clock edge: seed_load, then init, then normal progression.
REQ-014 SHALL, on seed_load in any state, capture seed, set i=0, enter SEED and clear dout_valid.
REQ-015 SHALL, in SEED, assert wen every cycle with waddr=i and wdata=x[i], where x[0]=seed and x[i]=(f*(x[i-1]^(x[i-1]>>(W-2)))+i) mod 2^W.
REQ-016 SHALL enter PRIME after the write with i=N-1.
REQ-017 SHALL, on init in any state, enter PRIME and clear dout_valid.
REQ-018 SHALL spend exactly 4 cycles in PRIME, asserting ren each cycle and prefetching x[0], x[1] and x[M], then enter RUN; wen SHALL be 0 in PRIME.
REQ-019 SHALL define advance = (state==RUN) and (dout_valid==0 or dout_ready==1).
REQ-020 SHALL, only on advance cycles, assert ren and wen with waddr=k and wdata = x[k+M] ^ (y>>1) ^ (y[0] ? A : 0), where y = (x[k] & upper) | (x[k+1] & ~upper) and all indices are mod N.
REQ-021 SHALL hold ren, wen and all internal pipeline registers when state is RUN and advance=0.
REQ-022 SHALL start k at 0 on entry to RUN and increment it per advance, wrapping N-1 -> 0; the read addresses SHALL wrap at N-1 -> 0 in the same way.
REQ-023 SHALL, on the edge ending an advance cycle, load dout with temper(wdata) and set dout_valid=1.
REQ-024 SHALL compute temper(x) as: y = x ^ ((x>>u) & D) with D = all-ones for W=32; then y ^= (y<<s) & B; then y ^= (y<<t) & C; then y ^= y>>l.
REQ-025 SHALL clear dout_valid on a handshake (dout_valid & dout_ready) when no advance occurs in the same cycle.
REQ-026 SHALL keep dout stable while dout_valid=1 and dout_ready=0.
REQ-027 SHALL first raise dout_valid 1 cycle after RUN entry when dout_ready=1.
REQ-028 SHALL sustain 1 word per cycle while dout_ready=1.
REQ-029 SHALL discard any in-progress SEED or PRIME sequence when seed_load or init arrives mid-sequence and restart it from index 0.
REQ-030 SHALL use only the low W bits of all arithmetic (modulo 2^W).

Reset
REQ-031 SHALL, on reset, set state=IDLE and set dout, dout_valid, busy, ren, wen, waddr, wdata, raddr0, raddr1 and all internal registers to 0.
REQ-032 SHALL remain in IDLE until seed_load or init is asserted.
REQ-033 SHALL, on reset asserted mid-operation, immediately force the reset values above, with no further RAM writes.

Verification
REQ-034 SHALL be verified with: W=32, seed_load with seed=5489, dout_ready=1 -> outputs 1..3 are 3499211612, 581869302, 3890346734.
REQ-035 SHALL be verified with: W=64, seed_load with seed=5489 -> first output is 14514284786278117030, second is 4620546740167642908.
REQ-036 SHALL be verified with: W=32 RUN, dout_ready=0 for 10 cycles -> dout held, wen=0, k frozen; on release the sequence continues with no lost or duplicated word.
REQ-037 SHALL be verified with: W=32, 1300 outputs -> all match the C reference model, and waddr wraps 623 -> 0 exactly twice.
REQ-038 SHALL be verified with: seed_load during RUN and reset asserted mid-SEED -> dout_valid drops, and the restarted stream matches REQ-034.
REQ-039 SHALL be verified with: RAM preloaded with the SEED image, init pulse -> output identical to REQ-034 and busy high for exactly 4 cycles.

Source files
------------

// File: rtl/mt_gen_par.sv
// Mersenne Twister (MT19937 / MT19937-64) generator over an external state RAM.
// It seeds the RAM itself or starts from a preloaded RAM, and streams tempered words with valid/ready.
module mt_gen_par #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          seed_load,
  input  logic [W-1:0]  seed,
  output logic          busy,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW-1:0] raddr0,
  output logic [AW-1:0] raddr1,
  output logic          ren,
  input  logic [W-1:0]  rdata0,
  input  logic [W-1:0]  rdata1,
  output logic [AW-1:0] waddr,
  output logic          wen,
  output logic [W-1:0]  wdata
);

  localparam bit IS64 = (W == 64);
  localparam int unsigned N = IS64 ? 312 : 624;
  localparam int unsigned M = IS64 ? 156 : 397;
  localparam int unsigned U = IS64 ? 29 : 11;
  localparam int unsigned S = IS64 ? 17 : 7;
  localparam int unsigned T = IS64 ? 37 : 15;
  localparam int unsigned L = IS64 ? 43 : 18;

  localparam logic [63:0] A64 = IS64 ? 64'hB502_6F5A_A966_19E9 : 64'h0000_0000_9908_B0DF;
  localparam logic [63:0] UP64 = IS64 ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000;
  localparam logic [63:0] D64 = IS64 ? 64'h5555_5555_5555_5555 : 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] B64 = IS64 ? 64'h71D6_7FFF_EDA6_0000 : 64'h0000_0000_9D2C_5680;
  localparam logic [63:0] C64 = IS64 ? 64'hFFF7_EEE0_0000_0000 : 64'h0000_0000_EFC6_0000;
  localparam logic [63:0] F64 = IS64 ? 64'd6364136223846793005 : 64'd1812433253;

  localparam logic [W-1:0] A     = A64[W-1:0];
  localparam logic [W-1:0] UPPER = UP64[W-1:0];
  localparam logic [W-1:0] D     = D64[W-1:0];
  localparam logic [W-1:0] B     = B64[W-1:0];
  localparam logic [W-1:0] C     = C64[W-1:0];
  localparam logic [W-1:0] F     = F64[W-1:0];

  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [AW-1:0] ADDR_M  = AW'(M);
  localparam logic [AW-1:0] ADDR_M1 = AW'(M + 1);

  if (W != 32 && W != 64) begin : g_bad_width
    $error("mt_gen_par: W must be 32 or 64");
  end
  if (AW < $clog2(N)) begin : g_bad_aw
    $error("mt_gen_par: AW too small for N");
  end

  typedef enum logic [1:0] {IDLE, SEED, PRIME, RUN} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  x_seed, xk, seed_nxt, y_mix, twist;
  logic [AW-1:0] idx, r0, r1;
  logic [1:0]    pcnt;
  logic          advance;

  function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + AW'(1);
  endfunction

  function automatic logic [W-1:0] temper(input logic [W-1:0] v);
    logic [W-1:0] y;
    y = v ^ ((v >> U) & D);
    y = y ^ ((y << S) & B);
    y = y ^ ((y << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  // x[k] lives in xk; x[k+1] and x[k+M] come straight off the read ports,
  // which hold their data across stalls because ren drops with advance.
  always_comb begin
    advance  = (state == RUN) && (!dout_valid || dout_ready);
    y_mix    = (xk & UPPER) | (rdata0 & ~UPPER);
    twist    = rdata1 ^ (y_mix >> 1) ^ (y_mix[0] ? A : '0);
    seed_nxt = F * (x_seed ^ (x_seed >> (W - 2))) + W'(idx) + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (seed_load) state_nxt = SEED;
    else if (init) state_nxt = PRIME;
    else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SEED:    if (idx == LAST) state_nxt = PRIME;
        PRIME:   if (pcnt == 2'd3) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state)
      SEED: begin
        busy  = 1'b1;
        wen   = 1'b1;
        waddr = idx;
        wdata = x_seed;
      end
      PRIME: begin
        busy = 1'b1;
        ren  = 1'b1;
      end
      RUN: begin
        ren   = advance;
        wen   = advance;
        waddr = idx;
        wdata = twist;
      end
      default: ;
    endcase
  end

  assign raddr0 = r0;
  assign raddr1 = r1;

  // PRIME: cycle 0 reads x[0]; cycles 1-3 read x[1]/x[M]; x[0] lands in xk after cycle 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_seed     <= '0;
      xk         <= '0;
      idx        <= '0;
      r0         <= '0;
      r1         <= '0;
      pcnt       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (seed_load) begin
      x_seed     <= seed;
      idx        <= '0;
      dout_valid <= 1'b0;
    end else if (init) begin
      pcnt       <= '0;
      r0         <= '0;
      r1         <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        SEED: begin
          x_seed <= seed_nxt;
          idx    <= inc_wrap(idx);
          if (idx == LAST) begin
            pcnt <= '0;
            r0   <= '0;
            r1   <= '0;
          end
        end
        PRIME: begin
          pcnt <= pcnt + 2'd1;
          case (pcnt)
            2'd0: begin
              r0 <= AW'(1);
              r1 <= ADDR_M;
            end
            2'd1: xk <= rdata0;
            2'd3: begin
              r0  <= AW'(2);
              r1  <= ADDR_M1;
              idx <= '0;
            end
            default: ;
          endcase
        end
        RUN: begin
          if (advance) begin
            idx        <= inc_wrap(idx);
            r0         <= inc_wrap(r0);
            r1         <= inc_wrap(r1);
            xk         <= rdata0;
            dout       <= temper(twist);
            dout_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mt_gen_par.sv
// Bench for mt_gen_par: W=32 instance against a batch MT19937 model, W=64 instance against known outputs.
module tb_mt_gen_par;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_init = 1'b0, a_seed_load = 1'b0, a_ready = 1'b0;
  logic [31:0] a_seed = '0;
  logic        a_busy, a_dout_valid, a_ren, a_wen;
  logic [31:0] a_dout, a_rdata0, a_rdata1, a_wdata;
  logic [9:0]  a_raddr0, a_raddr1, a_waddr;

  logic        b_init = 1'b0, b_seed_load = 1'b0, b_ready = 1'b1;
  logic [63:0] b_seed = '0;
  logic        b_busy, b_dout_valid, b_ren, b_wen;
  logic [63:0] b_dout, b_rdata0, b_rdata1, b_wdata;
  logic [9:0]  b_raddr0, b_raddr1, b_waddr;

  logic [31:0] mem32 [0:1023];
  logic [63:0] mem64 [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  int a_writes = 0;
  int wraps = 0;
  logic [9:0] last_waddr = '0;
  logic       last_run = 1'b0;

  logic [31:0] mt [624];
  int          mti = 624;

  always #5 clk = ~clk;

  mt_gen_par #(.W(32), .AW(10)) dut_a (
    .clk(clk), .reset(reset), .init(a_init), .seed_load(a_seed_load), .seed(a_seed),
    .busy(a_busy), .dout(a_dout), .dout_valid(a_dout_valid), .dout_ready(a_ready),
    .raddr0(a_raddr0), .raddr1(a_raddr1), .ren(a_ren), .rdata0(a_rdata0), .rdata1(a_rdata1),
    .waddr(a_waddr), .wen(a_wen), .wdata(a_wdata)
  );

  mt_gen_par #(.W(64), .AW(10)) dut_b (
    .clk(clk), .reset(reset), .init(b_init), .seed_load(b_seed_load), .seed(b_seed),
    .busy(b_busy), .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_ready),
    .raddr0(b_raddr0), .raddr1(b_raddr1), .ren(b_ren), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .waddr(b_waddr), .wen(b_wen), .wdata(b_wdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem32[pre_addr] <= pre_data;
    else if (a_wen) mem32[a_waddr] <= a_wdata;
    if (a_ren) begin
      a_rdata0 <= mem32[a_raddr0];
      a_rdata1 <= mem32[a_raddr1];
    end
    if (b_wen) mem64[b_waddr] <= b_wdata;
    if (b_ren) begin
      b_rdata0 <= mem64[b_raddr0];
      b_rdata1 <= mem64[b_raddr1];
    end
  end

  // Write-port observer: counts writes and RUN-phase 623 -> 0 address wraps.
  always @(posedge clk) begin
    if (a_wen) begin
      a_writes <= a_writes + 1;
      if (a_waddr == 10'd0 && last_waddr == 10'd623 && last_run) wraps <= wraps + 1;
      last_waddr <= a_waddr;
      last_run   <= !a_busy;
    end
  end

  function automatic void ref_seed(input logic [31:0] s);
    mt[0] = s;
    for (int i = 1; i < 624; i++)
      mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    mti = 624;
  endfunction

  function automatic logic [31:0] ref_next();
    logic [31:0] y;
    if (mti >= 624) begin
      for (int k = 0; k < 624; k++) begin
        y = (mt[k] & 32'h8000_0000) | (mt[(k + 1) % 624] & 32'h7FFF_FFFF);
        mt[k] = mt[(k + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'h0);
      end
      mti = 0;
    end
    y = mt[mti];
    mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic seed_dut(input logic [31:0] s);
    @(negedge clk);
    a_seed = s;
    a_seed_load = 1'b1;
    @(negedge clk);
    a_seed_load = 1'b0;
  endtask

  task automatic wait_busy(input int exp, input string tag);
    int c;
    c = 0;
    while (a_busy === 1'b1 && c < 2000) begin
      c++;
      @(negedge clk);
    end
    n_cmp++;
    if (c != exp) begin
      n_err++;
      $display("FAIL busy_len_%s: got %0d cycles expected %0d", tag, c, exp);
    end
  endtask

  task automatic run_entry(input string tag);
    a_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_at_entry_%s: got %b expected 0", tag, a_dout_valid);
    end
    @(negedge clk);
    a_ready = 1'b0;
    #1;
    n_cmp++;
    if (a_dout_valid !== 1'b1) begin
      n_err++;
      $display("FAIL valid_after_entry_%s: got %b expected 1", tag, a_dout_valid);
    end
  endtask

  task automatic run_words(input int n, input int prob, input string tag,
                           output logic [31:0] w0, output logic [31:0] w1, output logic [31:0] w2);
    int got, cyc;
    logic pv, pr;
    logic [31:0] pd, exp;
    got = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    w0 = '0; w1 = '0; w2 = '0;
    while (got < n && cyc < n * 20 + 100) begin
      @(negedge clk);
      a_ready = ($urandom_range(0, 99) < prob);
      #1;
      if (pv && !pr) begin
        n_cmp++;
        if (a_dout_valid !== 1'b1 || a_dout !== pd) begin
          n_err++;
          $display("FAIL hold_%s: got v=%b d=%h expected v=1 d=%h", tag, a_dout_valid, a_dout, pd);
        end
      end
      if (a_dout_valid && !a_ready) begin
        n_cmp++;
        if (a_wen !== 1'b0) begin
          n_err++;
          $display("FAIL stall_wen_%s: got %b expected 0", tag, a_wen);
        end
      end
      if (a_dout_valid && a_ready) begin
        exp = ref_next();
        n_cmp++;
        if (a_dout !== exp) begin
          n_err++;
          $display("FAIL word_%s[%0d]: got %0d expected %0d", tag, got, a_dout, exp);
        end
        if (got == 0) w0 = a_dout;
        if (got == 1) w1 = a_dout;
        if (got == 2) w2 = a_dout;
        got++;
      end
      pv = a_dout_valid; pr = a_ready; pd = a_dout;
      cyc++;
    end
    n_cmp++;
    if (got != n) begin
      n_err++;
      $display("FAIL timeout_%s: got %0d words expected %0d", tag, got, n);
    end
  endtask

  task automatic check_first3(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2);
    logic [31:0] e [3];
    logic [31:0] g [3];
    e[0] = 32'd3499211612; e[1] = 32'd581869302; e[2] = 32'd3890346734;
    g[0] = w0; g[1] = w1; g[2] = w2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (g[i] !== e[i]) begin
        n_err++;
        $display("FAIL known_%s[%0d]: got %0d expected %0d", tag, i, g[i], e[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_dout, a_dout_valid, a_busy, a_ren, a_wen, a_waddr, a_wdata, a_raddr0, a_raddr1} !== '0) begin
      n_err++;
      $display("FAIL reset_a: got dout=%h v=%b busy=%b ren=%b wen=%b wa=%0d wd=%h ra=%0d/%0d expected all 0",
               a_dout, a_dout_valid, a_busy, a_ren, a_wen, a_waddr, a_wdata, a_raddr0, a_raddr1);
    end
    n_cmp++;
    if ({b_dout, b_dout_valid, b_busy, b_wen} !== '0) begin
      n_err++;
      $display("FAIL reset_b: got dout=%h v=%b busy=%b wen=%b expected all 0",
               b_dout, b_dout_valid, b_busy, b_wen);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || a_wen !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: got busy=%b wen=%b expected 0/0", a_busy, a_wen);
    end
  endtask

  task automatic test_w64();
    logic [63:0] w [2];
    int got, c;
    got = 0; c = 0;
    @(negedge clk);
    b_seed = 64'd5489;
    b_seed_load = 1'b1;
    @(negedge clk);
    b_seed_load = 1'b0;
    while (got < 2 && c < 2000) begin
      @(negedge clk);
      if (b_dout_valid) begin
        w[got] = b_dout;
        got++;
      end
      c++;
    end
    n_cmp++;
    if (got != 2) begin
      n_err++;
      $display("FAIL w64_timeout: got %0d words expected 2", got);
    end else begin
      n_cmp++;
      if (w[0] !== 64'd14514284786278117030) begin
        n_err++;
        $display("FAIL w64_first: got %0d expected 14514284786278117030", w[0]);
      end
      n_cmp++;
      if (w[1] !== 64'd4620546740167642908) begin
        n_err++;
        $display("FAIL w64_second: got %0d expected 4620546740167642908", w[1]);
      end
    end
  endtask

  task automatic test_known();
    logic [31:0] w0, w1, w2;
    ref_seed(32'd5489);
    seed_dut(32'd5489);
    wait_busy(628, "known");
    run_entry("known");
    run_words(3, 100, "known", w0, w1, w2);
    check_first3("seed", w0, w1, w2);
  endtask

  task automatic test_stall();
    logic [31:0] w0, w1, w2, d0;
    logic [9:0]  ad;
    run_words(5, 100, "pre_stall", w0, w1, w2);
    @(negedge clk);
    a_ready = 1'b0;
    #1;
    d0 = a_dout;
    ad = a_waddr;
    n_cmp++;
    if (a_dout_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_valid: got %b expected 1", a_dout_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (a_dout !== d0 || a_wen !== 1'b0 || a_waddr !== ad || a_dout_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got d=%h wen=%b wa=%0d v=%b expected d=%h wen=0 wa=%0d v=1",
                 i, a_dout, a_wen, a_waddr, a_dout_valid, d0, ad);
      end
    end
    run_words(20, 100, "post_stall", w0, w1, w2);
  endtask

  task automatic test_long();
    logic [31:0] s, w0, w1, w2;
    int w_start;
    s = $urandom;
    ref_seed(s);
    seed_dut(s);
    wait_busy(628, "long");
    w_start = wraps;
    run_words(1300, 60, "long", w0, w1, w2);
    n_cmp++;
    if (wraps - w_start != 2) begin
      n_err++;
      $display("FAIL waddr_wraps: got %0d expected 2", wraps - w_start);
    end
  endtask

  task automatic test_seed_during_run();
    logic [31:0] w0, w1, w2;
    @(negedge clk);
    a_seed = 32'd5489;
    a_seed_load = 1'b1;
    a_ready = $urandom_range(0, 1) == 1;
    @(negedge clk);
    a_seed_load = 1'b0;
    #1;
    n_cmp++;
    if (a_dout_valid !== 1'b0 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL reseed_drop: got v=%b busy=%b expected 0/1", a_dout_valid, a_busy);
    end
    wait_busy(628, "reseed");
    ref_seed(32'd5489);
    run_entry("reseed");
    run_words(3, 100, "reseed", w0, w1, w2);
    check_first3("reseed", w0, w1, w2);
  endtask

  task automatic test_reset_mid_seed();
    logic [31:0] w0, w1, w2;
    int wr;
    seed_dut($urandom);
    repeat (100) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_busy, a_wen, a_dout_valid, a_waddr, a_wdata, a_ren} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_seed: got busy=%b wen=%b v=%b wa=%0d wd=%h ren=%b expected all 0",
               a_busy, a_wen, a_dout_valid, a_waddr, a_wdata, a_ren);
    end
    wr = a_writes;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_writes != wr) begin
      n_err++;
      $display("FAIL writes_in_reset: got %0d writes expected 0", a_writes - wr);
    end
    reset = 1'b0;
    ref_seed(32'd5489);
    seed_dut(32'd5489);
    wait_busy(628, "after_reset");
    run_entry("after_reset");
    run_words(3, 100, "after_reset", w0, w1, w2);
    check_first3("after_reset", w0, w1, w2);
  endtask

  task automatic test_init();
    logic [31:0] w0, w1, w2;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_seed(32'd5489);
    for (int i = 0; i < 624; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = 10'(i);
      pre_data = mt[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
    a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    wait_busy(4, "init");
    run_entry("init");
    run_words(3, 100, "init", w0, w1, w2);
    check_first3("init", w0, w1, w2);
  endtask

  initial begin
    test_reset();
    test_w64();
    test_known();
    test_stall();
    test_long();
    test_seed_during_run();
    test_reset_mid_seed();
    test_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
